weight_loader: RTL and testbench
================================

// Module: weight_loader
// PURPOSE
//  Writer side of the multiply-accumulate weight memories. Accepts a valid/ready stream
//  of 32-bit Q-format words and writes the first DEPTH words to bank A (multiplicand RAM)
//  and the next DEPTH words to bank B (multiplier RAM). Once both banks are full, it holds
//  mac_start high so the multiply-accumulate block can begin reading. Sits between the
//  host/stream interface and the two single-port weight block RAMs.
// PARAMETERS
//  WIDTH   32  data word width (Q-format, matches qmult/qadd #(19,32))
//  DEPTH   10  words per bank; total words per load = 2*DEPTH
//  ADDR_W  4   RAM address width; DEPTH <= 2**ADDR_W
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  load_req   in   1       1-cycle pulse: begin a new load sequence
//  in_valid   in   1       stream word present
//  in_data    in   WIDTH   stream word
//  in_ready   out  1       loader can accept a word this cycle
//  wr_addr    out  ADDR_W  RAM write address (shared by both banks)
//  wr_data    out  WIDTH   RAM write data
//  wr_en_a    out  1       write strobe, bank A
//  wr_en_b    out  1       write strobe, bank B
//  busy       out  1       high in LOAD_A/LOAD_B
//  mac_start  out  1       level: both banks loaded, MAC may run
//  checksum   out  WIDTH   XOR of all words accepted in the current load
// BEHAVIOUR
//  States: IDLE, LOAD_A, LOAD_B, DONE. Word counter cnt (0..DEPTH-1).
//  Reset: state=IDLE, cnt=0; wr_addr=0, wr_data=0, wr_en_a=wr_en_b=0, in_ready=0, busy=0,
//   mac_start=0, checksum=0. Reset mid-load abandons the load; no partial mac_start.
//  IDLE: in_ready=0. On load_req -> LOAD_A, cnt=0, checksum=0.
//  LOAD_A/LOAD_B: in_ready=1 (registered on state entry; combinational from state).
//   Accept = in_valid & in_ready. On accept: next cycle wr_addr=cnt, wr_data=in_data,
//   wr_en_x=1 for exactly one cycle (write latency 1); checksum ^= in_data; cnt++.
//   No accept -> cnt holds, strobes 0. Stream may stall arbitrarily; words are never dropped.
//  LOAD_A, accept with cnt==DEPTH-1: cnt->0, state -> LOAD_B.
//  LOAD_B, accept with cnt==DEPTH-1: state -> DONE; the final wr_en_b occurs the
//   same cycle as mac_start rises.
//  DONE: in_ready=0, mac_start=1 (held). load_req -> LOAD_A, mac_start=0 next cycle,
//   checksum=0, cnt=0.
//  load_req while busy: ignored. load_req and rst in the same cycle: rst wins.
//  wr_en_a and wr_en_b are never high together. In_data is ignored when in_ready=0.
//  busy = (state==LOAD_A)|(state==LOAD_B).
// TESTING
//  1. rst, load_req, stream 1..20 with in_valid held high -> bank A addr0..9 = 1..10,
//     bank B addr0..9 = 11..20; mac_start rises with the 20th write strobe; checksum=0x14.
//  2. Same stream with in_valid toggled randomly (50%) -> identical RAM contents and
//     checksum; no strobe on non-accept cycles.
//  3. rst asserted after the 13th accepted word -> all outputs return to reset values;
//     a new load_req then reloads fully from bank A addr0.
//  4. load_req pulsed during LOAD_B -> ignored; sequence completes normally with
//     20 writes total.
//  5. In DONE, load_req -> mac_start drops next cycle; in_ready=1; second load of
//     0xFFFFFFFF x20 -> checksum=0, mac_start=1 again.
//  6. in_valid high while IDLE/DONE -> in_ready=0, no write strobes, checksum unchanged.

Source files
------------

// File: rtl/weight_loader_if.sv
// Stream-in and RAM-write bundle for weight_loader.
// slave: in_valid/in_data in, in_ready + wr_addr/wr_data/wr_en_a/wr_en_b out.
interface weight_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_en_a;
  logic              wr_en_b;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_addr, wr_data,
    input  wr_en_a, wr_en_b
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_addr, wr_data,
    output wr_en_a, wr_en_b
  );
endinterface

// File: rtl/weight_loader.sv
// Streams 2*DEPTH words into bank A then bank B; holds mac_start when full.
// Ports: clk, rst, load_req, bus (stream+write), busy, mac_start, checksum.
module weight_loader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req,
  weight_loader_if.slave   bus,
  output logic             busy,
  output logic             mac_start,
  output logic [WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [WIDTH-1:0]  r_csum;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_data;
  logic              r_en_a;
  logic              r_en_b;

  logic w_ready;
  logic w_busy;
  logic w_mac;
  logic w_clr;
  logic w_accept;
  logic w_last;

  assign w_accept = bus.in_valid & w_ready;
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_mac   = 1'b0;
    w_clr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (load_req) begin
          w_next = S_LOAD_A;
          w_clr  = 1'b1;
        end
      end
      S_LOAD_A: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (bus.in_valid && w_last)
          w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (bus.in_valid && w_last)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_mac = 1'b1;
        if (load_req) begin
          w_next = S_LOAD_A;
          w_clr  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Write port lags the accept by one cycle; the
  // counter wraps at the bank boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_csum <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_en_a <= 1'b0;
      r_en_b <= 1'b0;
    end else begin
      r_en_a <= w_accept &
                (r_state == S_LOAD_A);
      r_en_b <= w_accept &
                (r_state == S_LOAD_B);
      if (w_clr) begin
        r_cnt  <= '0;
        r_csum <= '0;
      end else if (w_accept) begin
        r_addr <= r_cnt;
        r_data <= bus.in_data;
        r_csum <= r_csum ^ bus.in_data;
        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.wr_addr  = r_addr;
  assign bus.wr_data  = r_data;
  assign bus.wr_en_a  = r_en_a;
  assign bus.wr_en_b  = r_en_b;
  assign busy         = w_busy;
  assign mac_start    = w_mac;
  assign checksum     = r_csum;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: vector table,
// then model-checked stream sequences.
module tb_weight_loader;

  localparam int DEPTH = 10;

  logic        clk;
  logic        rst;
  logic        load_req;
  logic        busy;
  logic        mac_start;
  logic [31:0] checksum;

  weight_loader_if #(.WIDTH(32), .ADDR_W(4)) bus ();

  weight_loader #(
    .WIDTH (32),
    .DEPTH (DEPTH),
    .ADDR_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_req (load_req),
    .bus      (bus),
    .busy     (busy),
    .mac_start(mac_start),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: words taken in this load,
  // loading/done flags, last write seen
  int          m_k;
  bit          m_load;
  bit          m_done;
  logic [31:0] m_csum;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  bit          m_ena;
  bit          m_enb;

  logic [31:0] bank_a [16];
  logic [31:0] bank_b [16];
  int          nwr;
  bit          last_mac;

  typedef struct {
    bit          r;
    bit          lr;
    bit          v;
    logic [31:0] d;
    bit          rdy;
    bit          bsy;
    bit          mac;
    bit          ea;
    bit          eb;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] cs;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm,
                     input logic [72:0] a,
                     input logic [72:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, a, e);
    end
  endtask

  function automatic logic [72:0] outs();
    return {bus.in_ready, busy, mac_start,
            bus.wr_en_a, bus.wr_en_b,
            bus.wr_addr, bus.wr_data, checksum};
  endfunction

  task automatic clear_banks();
    for (int i = 0; i < 16; i++) begin
      bank_a[i] = '0;
      bank_b[i] = '0;
    end
    nwr      = 0;
    last_mac = 1'b0;
  endtask

  task automatic cyc(input bit r, input bit lr,
                     input bit v,
                     input logic [31:0] d);
    rst          = r;
    load_req     = lr;
    bus.in_valid = v;
    bus.in_data  = d;
    m_ena = 1'b0;
    m_enb = 1'b0;
    if (r) begin
      m_k    = 0;
      m_load = 1'b0;
      m_done = 1'b0;
      m_csum = '0;
      m_addr = '0;
      m_data = '0;
    end else if (v && m_load) begin
      m_ena  = (m_k < DEPTH);
      m_enb  = !m_ena;
      m_addr = 4'(m_k % DEPTH);
      m_data = d;
      m_csum = m_csum ^ d;
      m_k++;
      if (m_k == 2 * DEPTH) begin
        m_load = 1'b0;
        m_done = 1'b1;
      end
    end else if (lr && !m_load) begin
      m_load = 1'b1;
      m_done = 1'b0;
      m_k    = 0;
      m_csum = '0;
    end
    @(posedge clk);
    #1;
    chk("cycle", outs(),
        {m_load, m_load, m_done, m_ena, m_enb,
         m_addr, m_data, m_csum});
    if (bus.wr_en_a) begin
      bank_a[bus.wr_addr] = bus.wr_data;
      nwr++;
    end
    if (bus.wr_en_b) begin
      bank_b[bus.wr_addr] = bus.wr_data;
      nwr++;
      if (bus.wr_addr == 4'd9)
        last_mac = mac_start;
    end
  endtask

  task automatic stream(input bit rnd,
                        input bit ones,
                        input int stop,
                        input int lr_at);
    int          n;
    int          budget;
    bit          v;
    bit          will;
    logic [31:0] d;
    n      = 0;
    budget = 0;
    while (n < stop && budget < 400) begin
      v    = rnd ? bit'($urandom_range(0, 1))
                 : 1'b1;
      d    = ones ? 32'hFFFF_FFFF
                  : 32'(n + 1);
      if (!v) d = $urandom;
      will = v && m_load;
      cyc(1'b0, n == lr_at, v, d);
      if (will) n++;
      budget++;
    end
    chk("stream_done", 73'(n), 73'(stop));
  endtask

  task automatic chk_banks(input string nm);
    for (int i = 0; i < DEPTH; i++) begin
      chk({nm, "_a"}, 73'(bank_a[i]),
          73'(i + 1));
      chk({nm, "_b"}, 73'(bank_b[i]),
          73'(i + 11));
    end
    chk({nm, "_nwr"}, 73'(nwr), 73'd20);
    chk({nm, "_csum"}, 73'(checksum),
        73'h14);
    chk({nm, "_mac"}, 73'(last_mac), 73'd1);
  endtask

  initial begin
    rst          = 1'b1;
    load_req     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    m_k          = 0;
    m_load       = 1'b0;
    m_done       = 1'b0;
    m_csum       = '0;
    m_addr       = '0;
    m_data       = '0;
    clear_banks();

    tbl[0] = '{1,0,0,32'd0, 0,0,0,0,0,4'd0,32'd0,32'd0};
    tbl[1] = '{0,0,1,32'd5, 0,0,0,0,0,4'd0,32'd0,32'd0};
    tbl[2] = '{0,1,1,32'd7, 1,1,0,0,0,4'd0,32'd0,32'd0};
    tbl[3] = '{0,0,1,32'd1, 1,1,0,1,0,4'd0,32'd1,32'd1};
    tbl[4] = '{0,0,0,32'd9, 1,1,0,0,0,4'd0,32'd1,32'd1};
    tbl[5] = '{0,0,1,32'd2, 1,1,0,1,0,4'd1,32'd2,32'd3};
    tbl[6] = '{0,1,1,32'd4, 1,1,0,1,0,4'd2,32'd4,32'd7};
    tbl[7] = '{1,0,1,32'd8, 0,0,0,0,0,4'd0,32'd0,32'd0};

    for (int i = 0; i < 8; i++) begin
      rst          = tbl[i].r;
      load_req     = tbl[i].lr;
      bus.in_valid = tbl[i].v;
      bus.in_data  = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].rdy, tbl[i].bsy, tbl[i].mac,
           tbl[i].ea, tbl[i].eb, tbl[i].addr,
           tbl[i].data, tbl[i].cs});
    end

    // full load, valid held high
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    clear_banks();
    stream(1'b0, 1'b0, 20, -1);
    chk_banks("held");
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 1'b1, $urandom);
    chk("done_csum", 73'(checksum), 73'h14);

    // reload from DONE, random stalls
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("relaunch", {70'd0, mac_start,
        bus.in_ready, busy}, 73'b011);
    clear_banks();
    stream(1'b1, 1'b0, 20, -1);
    chk_banks("stall");

    // reset after 13 words, then full reload
    cyc(1'b0, 1'b1, 1'b0, '0);
    stream(1'b1, 1'b0, 13, -1);
    cyc(1'b1, 1'b0, 1'b1, $urandom);
    chk("abort", outs(), 73'd0);
    cyc(1'b0, 1'b0, 1'b1, $urandom);
    cyc(1'b0, 1'b1, 1'b0, '0);
    clear_banks();
    stream(1'b1, 1'b0, 20, -1);
    chk_banks("reload");

    // load_req during bank B is ignored
    cyc(1'b0, 1'b1, 1'b0, '0);
    clear_banks();
    stream(1'b1, 1'b0, 20, 14);
    chk_banks("lr_busy");

    // all-ones load cancels to zero checksum
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("drop_mac", {71'd0, mac_start,
        bus.in_ready}, 73'b01);
    stream(1'b1, 1'b1, 20, -1);
    chk("ones_csum", 73'(checksum), 73'd0);
    chk("ones_mac", 73'(mac_start), 73'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
